// File: rtl/bu_bank_loader_pkg.sv
// Shared sizing and types for the bu bank loader: word geometry and counter widths.
package bu_bank_loader_pkg;

   localparam int BU_WORDS = 4;
   localparam int WORD_W   = 32;
   localparam int WR_CNT_W = 3;
   localparam int RD_IDX_W = 2;

   localparam logic [WR_CNT_W-1:0] WR_FULL = WR_CNT_W'(BU_WORDS);
   localparam logic [RD_IDX_W-1:0] RD_LAST = RD_IDX_W'(BU_WORDS - 1);

   typedef logic [WORD_W-1:0]                word_t;
   typedef logic [BU_WORDS-1:0][WORD_W-1:0] bank_t;

endpackage

// File: rtl/bu_bank_loader_bank_reg.sv
// One 4x32 bank of the ping-pong pair: indexed write, whole bank visible on q.
module bu_bank_reg
   import bu_bank_loader_pkg::*;
(
   input  logic                clock,
   input  logic                areset,
   input  logic                we,
   input  logic [RD_IDX_W-1:0] idx,
   input  word_t               wdata,
   output bank_t               q
);

   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         q <= '0;
      end else if (we) begin
         q[idx] <= wdata;
      end
   end

endmodule

// File: rtl/bu_bank_loader.sv
// Ping-pong loader collecting 4-word bu groups for a downstream selector.
// Optional sticky underflow_err output when BU_LOADER_ERR_EN is defined.
module bu_bank_loader
   import bu_bank_loader_pkg::*;
(
   input  logic                clock,
   input  logic                areset,
   input  logic                in_valid,
   input  logic [WORD_W-1:0]   in_data,
   output logic                in_ready,
   input  logic                diag_done,
   output logic [WORD_W-1:0]   bu1,
   output logic [WORD_W-1:0]   bu2,
   output logic [WORD_W-1:0]   bu3,
   output logic [WORD_W-1:0]   bu4,
   output logic                bank_valid,
   output logic [RD_IDX_W-1:0] rd_idx
`ifdef BU_LOADER_ERR_EN
   ,
   output logic                underflow_err
`endif
);

   logic [WR_CNT_W-1:0] wr_cnt;
   logic                bank_sel;
   logic                accept;
   logic                consume;
   logic                rd_free;
   logic                swap;
   logic                we0;
   logic                we1;
   bank_t               q0;
   bank_t               q1;
   bank_t               rd_bank;

   assign in_ready = (wr_cnt != WR_FULL);
   assign accept   = in_valid && in_ready;
   assign consume  = diag_done && bank_valid;
   // The read bank counts as free when the last word is being consumed this edge.
   assign rd_free  = !bank_valid || (consume && (rd_idx == RD_LAST));
   assign swap     = (wr_cnt == WR_FULL) && rd_free;

   // bank_sel names the read bank; the write bank is always the other one.
   assign we0 = accept && bank_sel;
   assign we1 = accept && !bank_sel;

   bu_bank_reg u_bank0 (
      .clock  (clock),
      .areset (areset),
      .we     (we0),
      .idx    (wr_cnt[RD_IDX_W-1:0]),
      .wdata  (in_data),
      .q      (q0)
   );

   bu_bank_reg u_bank1 (
      .clock  (clock),
      .areset (areset),
      .we     (we1),
      .idx    (wr_cnt[RD_IDX_W-1:0]),
      .wdata  (in_data),
      .q      (q1)
   );

   assign rd_bank = bank_sel ? q1 : q0;
   assign bu1     = rd_bank[0];
   assign bu2     = rd_bank[1];
   assign bu3     = rd_bank[2];
   assign bu4     = rd_bank[3];

   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         wr_cnt     <= '0;
         rd_idx     <= '0;
         bank_sel   <= 1'b0;
         bank_valid <= 1'b0;
      end else if (swap) begin
         bank_sel   <= !bank_sel;
         wr_cnt     <= '0;
         rd_idx     <= '0;
         bank_valid <= 1'b1;
      end else begin
         if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
         if (consume) begin
            rd_idx <= rd_idx + 1'b1;
            if (rd_idx == RD_LAST) begin
               bank_valid <= 1'b0;
            end
         end
      end
   end

`ifdef BU_LOADER_ERR_EN
   always_ff @(posedge clock or posedge areset) begin
      if (areset) begin
         underflow_err <= 1'b0;
      end else if (diag_done && !bank_valid) begin
         underflow_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bu_bank_loader.sv
// Directed bench for bu_bank_loader: vector table plus reset/underflow sequences.
module tb_bu_bank_loader;

   logic        clock;
   logic        areset;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        diag_done;
   logic [31:0] bu1, bu2, bu3, bu4;
   logic        bank_valid;
   logic [1:0]  rd_idx;
`ifdef BU_LOADER_ERR_EN
   logic        underflow_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   bu_bank_loader dut (
      .clock      (clock),
      .areset     (areset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .diag_done  (diag_done),
      .bu1        (bu1),
      .bu2        (bu2),
      .bu3        (bu3),
      .bu4        (bu4),
      .bank_valid (bank_valid),
      .rd_idx     (rd_idx)
`ifdef BU_LOADER_ERR_EN
      ,
      .underflow_err (underflow_err)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        dd;
      logic        rdy;
      logic        bv;
      logic [1:0]  idx;
      logic [31:0] b1, b2, b3, b4;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic v, input logic [31:0] d, input logic dd,
                      input logic rdy, input logic bv, input logic [1:0] idx,
                      input logic [31:0] b1, input logic [31:0] b2,
                      input logic [31:0] b3, input logic [31:0] b4);
      vec_t t;
      t.v = v; t.d = d; t.dd = dd; t.rdy = rdy; t.bv = bv; t.idx = idx;
      t.b1 = b1; t.b2 = b2; t.b3 = b3; t.b4 = b4;
      vecs.push_back(t);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic rdy, input logic bv,
                             input logic [1:0] idx, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3,
                             input logic [31:0] b4);
      check({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, rdy});
      check({tag, ".bank_valid"}, {31'd0, bank_valid}, {31'd0, bv});
      check({tag, ".rd_idx"},     {30'd0, rd_idx},     {30'd0, idx});
      check({tag, ".bu1"}, bu1, b1);
      check({tag, ".bu2"}, bu2, b2);
      check({tag, ".bu3"}, bu3, b3);
      check({tag, ".bu4"}, bu4, b4);
   endtask

   task automatic cyc(input logic v, input logic [31:0] d, input logic dd);
      in_valid  = v;
      in_data   = d;
      diag_done = dd;
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Expected values are the outputs just after the edge that consumes the inputs.
      // single group, latency 1
      add(1, 32'h11, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 32'h22, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 32'h33, 0, 1, 0, 0, 0, 0, 0, 0);
      add(1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 32'h0,  0, 1, 1, 0, 32'h11, 32'h22, 32'h33, 32'h44);
      // consumption
      add(0, 32'h0,  1, 1, 1, 1, 32'h11, 32'h22, 32'h33, 32'h44);
      add(0, 32'h0,  1, 1, 1, 2, 32'h11, 32'h22, 32'h33, 32'h44);
      add(0, 32'h0,  1, 1, 1, 3, 32'h11, 32'h22, 32'h33, 32'h44);
      add(0, 32'h0,  1, 1, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
      // stray strobe
      add(0, 32'h0,  1, 1, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
      // backpressure: 8 words, no strobes
      add(1, 32'hA1, 0, 1, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
      add(1, 32'hA2, 0, 1, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
      add(1, 32'hA3, 0, 1, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
      add(1, 32'hA4, 0, 0, 0, 0, 32'h11, 32'h22, 32'h33, 32'h44);
      add(1, 32'hB1, 0, 1, 1, 0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      add(1, 32'hB1, 0, 1, 1, 0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      add(1, 32'hB2, 0, 1, 1, 0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      add(1, 32'hB3, 0, 1, 1, 0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      add(1, 32'hB4, 0, 0, 1, 0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      // 9th word held until the 4th strobe, which swaps seamlessly
      add(1, 32'hC1, 0, 0, 1, 0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      add(1, 32'hC1, 1, 0, 1, 1, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      add(1, 32'hC1, 1, 0, 1, 2, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      add(1, 32'hC1, 1, 0, 1, 3, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
      add(1, 32'hC1, 1, 1, 1, 0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
      add(1, 32'hC1, 0, 1, 1, 0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
      add(1, 32'hC2, 1, 1, 1, 1, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
      add(1, 32'hC3, 1, 1, 1, 2, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
      add(1, 32'hC4, 1, 0, 1, 3, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
      add(0, 32'h0,  1, 1, 1, 0, 32'hC1, 32'hC2, 32'hC3, 32'hC4);

      in_valid  = 1'b0;
      in_data   = '0;
      diag_done = 1'b0;
      areset    = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check_outs("reset", 1, 0, 0, 0, 0, 0, 0);
      areset = 1'b0;
      @(posedge clock);
      #1;
      check({"post_reset.in_ready"}, {31'd0, in_ready}, 32'd1);
`ifdef BU_LOADER_ERR_EN
      check("post_reset.underflow_err", {31'd0, underflow_err}, 32'd0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         cyc(vecs[i].v, vecs[i].d, vecs[i].dd);
         check_outs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].bv, vecs[i].idx,
                    vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].b4);
      end

`ifdef BU_LOADER_ERR_EN
      check("stray.underflow_err", {31'd0, underflow_err}, 32'd1);
`endif

      // mid-group reset: two words of a new group, then an asynchronous reset
      cyc(1, 32'hD1, 0);
      cyc(1, 32'hD2, 0);
      in_valid = 1'b0;
      #2 areset = 1'b1;
      #1;
      check_outs("midreset", 1, 0, 0, 0, 0, 0, 0);
`ifdef BU_LOADER_ERR_EN
      check("midreset.underflow_err", {31'd0, underflow_err}, 32'd0);
`endif
      @(posedge clock);
      #1 areset = 1'b0;
      cyc(1, 32'hE1, 0);
      cyc(1, 32'hE2, 0);
      cyc(1, 32'hE3, 0);
      cyc(1, 32'hE4, 0);
      check_outs("fresh_full", 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 32'h0, 0);
      check_outs("fresh_swap", 1, 1, 0, 32'hE1, 32'hE2, 32'hE3, 32'hE4);
      cyc(0, 32'h0, 1);
      check_outs("fresh_consume", 1, 1, 1, 32'hE1, 32'hE2, 32'hE3, 32'hE4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
